// File: rtl/crc8_tx_appender_if.sv
// Byte-stream bundle for the CRC-8 transmit appender: an input stream from the frame source
// and an output stream to the link, each with a valid/ready handshake.
interface crc8_tx_appender_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_is_crc;
    logic       out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_is_crc
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_is_crc
    );
endinterface

// File: rtl/crc8_tx_appender.sv
// Forwards a framed byte stream and appends a CRC-8 byte (MSB-first, non-reflected) after the last byte.
// Optional macro CRC8_TX_ERR_INJECT_EN adds err_inject, which flips bit 0 of the emitted CRC byte.
//
// state | meaning
// IDLE  | no frame; CRC held at INIT, waiting for start
// DATA  | passing data bytes through, accumulating CRC
// CRC   | waiting for the output slot to load the CRC byte
// WAIT  | CRC byte presented, waiting for downstream to accept it
module crc8_tx_appender #(
    parameter logic [7:0] POLY  = 8'h07,
    parameter logic [7:0] INIT  = 8'h00,
    parameter int         CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef CRC8_TX_ERR_INJECT_EN
    input  logic             err_inject,
`endif
    crc8_tx_appender_if.slave bus,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [1:0] {IDLE, DATA, CRC, WAIT} state_t;

    state_t     state;
    logic [7:0] crc;
    logic [7:0] crc_out;
    logic       slot_free;

    function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            c = {c[6:0], 1'b0} ^ ((c[7] ^ d[7-i]) ? POLY : 8'h00);
        end
        return c;
    endfunction

`ifdef CRC8_TX_ERR_INJECT_EN
    assign crc_out = crc ^ {7'b0, err_inject};
`else
    assign crc_out = crc;
`endif

    assign slot_free   = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = (state == DATA) && slot_free;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            crc            <= INIT;
            bus.out_data   <= 8'h00;
            bus.out_valid  <= 1'b0;
            bus.out_last   <= 1'b0;
            bus.out_is_crc <= 1'b0;
            done           <= 1'b0;
            byte_count     <= '0;
        end else begin
            done <= 1'b0;
            // Accepted beat empties the slot unless a new byte is loaded below.
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    crc <= INIT;
                    if (start) begin
                        byte_count <= '0;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (bus.in_valid && slot_free) begin
                        bus.out_data   <= bus.in_data;
                        bus.out_valid  <= 1'b1;
                        bus.out_last   <= 1'b0;
                        bus.out_is_crc <= 1'b0;
                        crc            <= crc8_byte(crc, bus.in_data);
                        if (byte_count != {CNT_W{1'b1}}) begin
                            byte_count <= byte_count + CNT_W'(1);
                        end
                        if (bus.in_last) begin
                            state <= CRC;
                        end
                    end
                end
                CRC: begin
                    if (slot_free) begin
                        bus.out_data   <= crc_out;
                        bus.out_valid  <= 1'b1;
                        bus.out_last   <= 1'b1;
                        bus.out_is_crc <= 1'b1;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.out_ready) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
